gate_bist_ctrl: RTL and testbench

//  Sequencing controller for built-in self-test of one 2-input primitive gate (gate_xnor, gate_and, ...).
//  On start it drives the four input vectors onto the gate and waits a settle time per vector.
//  It then compares the gate output against a truth-table parameter and records per-vector failures.
//  It also keeps cumulative pass/fail run counters; it sits between a test host and the gate instance.

---
 rtl/gate_bist_if.sv | 27 ++
 rtl/gate_bist_ctrl.sv | 166 ++++++++++++++++
 tb/tb_gate_bist_ctrl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/gate_bist_if.sv
// Host/gate-side signal bundle of the gate BIST controller.
// The master side is the test host plus the gate under test; the slave side is the controller.
interface gate_bist_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             abort;
    logic             gate_s;
    logic             gate_a;
    logic             gate_b;
    logic             busy;
    logic             done;
    logic             pass;
    logic [3:0]       fail_vec;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output start, abort, gate_s,
        input  gate_a, gate_b, busy, done, pass, fail_vec, pass_cnt, fail_cnt
    );

    modport slave (
        input  start, abort, gate_s,
        output gate_a, gate_b, busy, done, pass, fail_vec, pass_cnt, fail_cnt
    );
endinterface

// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for one 2-input gate: walks the four input vectors,
// compares the gate output against TRUTH and keeps saturating pass/fail run counters.
module gate_bist_ctrl #(
    parameter logic [3:0] TRUTH  = 4'b1001,
    parameter int         SETTLE = 2,
    parameter int         CNT_W  = 8
) (
    input  logic        clk,
    input  logic        reset,
    gate_bist_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             gate_a_q, gate_a_d;
    logic             gate_b_q, gate_b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [3:0]       fail_vec_q, fail_vec_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic             mismatch_s;

    // Next-state and next-output computation; X on gate_s is scored as a mismatch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        gate_a_d   = gate_a_q;
        gate_b_d   = gate_b_q;
        pass_d     = pass_q;
        fail_vec_d = fail_vec_q;
        pass_cnt_d = pass_cnt_q;
        fail_cnt_d = fail_cnt_q;
        mismatch_s = (bus.gate_s !== TRUTH[idx_q]);

        case (state_q)
            ST_IDLE: begin
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
                if (bus.start) begin
                    state_d    = ST_SETTLE;
                    idx_d      = 2'd0;
                    cnt_d      = 8'd0;
                    fail_vec_d = 4'b0000;
                    pass_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    idx_d    = 2'd0;
                    cnt_d    = 8'd0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_CHECK;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CHECK: begin
                if (bus.abort) begin
                    state_d  = ST_IDLE;
                    idx_d    = 2'd0;
                    gate_a_d = 1'b0;
                    gate_b_d = 1'b0;
                end else begin
                    fail_vec_d[idx_q] = mismatch_s;
                    if (idx_q == 2'd3) begin
                        // Result and counters become visible together with the done pulse.
                        state_d = ST_DONE;
                        pass_d  = (fail_vec_d == 4'b0000);
                        if (fail_vec_d == 4'b0000) begin
                            if (pass_cnt_q != CNT_MAX) begin
                                pass_cnt_d = pass_cnt_q + CNT_ONE;
                            end else begin
                                pass_cnt_d = pass_cnt_q;
                            end
                        end else begin
                            if (fail_cnt_q != CNT_MAX) begin
                                fail_cnt_d = fail_cnt_q + CNT_ONE;
                            end else begin
                                fail_cnt_d = fail_cnt_q;
                            end
                        end
                    end else begin
                        state_d  = ST_SETTLE;
                        idx_d    = idx_q + 2'd1;
                        gate_a_d = idx_d[0];
                        gate_b_d = idx_d[1];
                    end
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                idx_d    = 2'd0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                idx_d    = 2'd0;
                cnt_d    = 8'd0;
                gate_a_d = 1'b0;
                gate_b_d = 1'b0;
            end
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CHECK);
        done_d = (state_d == ST_DONE);
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            cnt_q      <= 8'd0;
            gate_a_q   <= 1'b0;
            gate_b_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            fail_vec_q <= 4'b0000;
            pass_cnt_q <= {CNT_W{1'b0}};
            fail_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            gate_a_q   <= gate_a_d;
            gate_b_q   <= gate_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            fail_vec_q <= fail_vec_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign bus.gate_a   = gate_a_q;
    assign bus.gate_b   = gate_b_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pass     = pass_q;
    assign bus.fail_vec = fail_vec_q;
    assign bus.pass_cnt = pass_cnt_q;
    assign bus.fail_cnt = fail_cnt_q;
endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Bench for gate_bist_ctrl: a run-phase model predicts every output each cycle for an
// 8-bit-counter instance and a 2-bit-counter instance sharing the same stimulus.
module tb_gate_bist_ctrl;
    localparam logic [3:0] TRUTH_M = 4'b1001;
    localparam int         S       = 2;
    localparam int         RUN_LEN = 4 * (S + 1);

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic abort;
    int   mode;
    int   n_assert = 0;
    int   n_fail   = 0;

    gate_bist_if #(.CNT_W(8)) bus8 ();
    gate_bist_if #(.CNT_W(2)) bus2 ();

    function automatic logic gfun(input int md, input logic a, input logic b);
        case (md)
            0:       return ~(a ^ b);
            1:       return a ^ b;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign bus8.start  = start;
    assign bus8.abort  = abort;
    assign bus8.gate_s = gfun(mode, bus8.gate_a, bus8.gate_b);
    assign bus2.start  = start;
    assign bus2.abort  = abort;
    assign bus2.gate_s = gfun(mode, bus2.gate_a, bus2.gate_b);

    gate_bist_ctrl #(.TRUTH(4'b1001), .SETTLE(2), .CNT_W(8)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
    gate_bist_ctrl #(.TRUTH(4'b1001), .SETTLE(2), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1..RUN_LEN inside a run, RUN_LEN+1 the done cycle.
    int         m_phase;
    logic [3:0] m_fail;
    logic       m_pass, m_a, m_b;
    int         m_pc, m_fc, m_pc2, m_fc2;
    int         m_k, m_v, m_vn;
    logic       m_chk;
    logic [3:0] m_nf;

    always_comb begin
        m_k   = (m_phase >= 1 && m_phase <= RUN_LEN) ? m_phase - 1 : 0;
        m_v   = m_k / (S + 1);
        m_chk = (m_phase >= 1 && m_phase <= RUN_LEN) && (m_k % (S + 1) == S);
        m_vn  = m_phase / (S + 1);
        m_nf  = m_fail;
        if (m_chk) m_nf[m_v] = (gfun(mode, 1'((m_v & 1) != 0), 1'((m_v & 2) != 0)) != TRUTH_M[m_v]);
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= 0; m_fail <= 4'b0000; m_pass <= 1'b0; m_a <= 1'b0; m_b <= 1'b0;
            m_pc <= 0; m_fc <= 0; m_pc2 <= 0; m_fc2 <= 0;
        end else if (m_phase == 0) begin
            m_a <= 1'b0; m_b <= 1'b0;
            if (start) begin
                m_phase <= 1; m_fail <= 4'b0000; m_pass <= 1'b0;
            end
        end else if (m_phase == RUN_LEN + 1) begin
            m_phase <= 0; m_a <= 1'b0; m_b <= 1'b0;
        end else if (abort) begin
            m_phase <= 0; m_a <= 1'b0; m_b <= 1'b0;
        end else begin
            m_fail <= m_nf;
            if (m_phase == RUN_LEN) begin
                m_phase <= RUN_LEN + 1;
                m_pass  <= (m_nf == 4'b0000);
                if (m_nf == 4'b0000) begin
                    m_pc  <= (m_pc  < 255) ? m_pc + 1  : m_pc;
                    m_pc2 <= (m_pc2 < 3)   ? m_pc2 + 1 : m_pc2;
                end else begin
                    m_fc  <= (m_fc  < 255) ? m_fc + 1  : m_fc;
                    m_fc2 <= (m_fc2 < 3)   ? m_fc2 + 1 : m_fc2;
                end
            end else begin
                m_phase <= m_phase + 1;
                m_a     <= 1'((m_vn & 1) != 0);
                m_b     <= 1'((m_vn & 2) != 0);
            end
        end
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        chk("busy",     32'(bus8.busy),     32'(m_phase >= 1 && m_phase <= RUN_LEN));
        chk("done",     32'(bus8.done),     32'(m_phase == RUN_LEN + 1));
        chk("gate_a",   32'(bus8.gate_a),   32'(m_a));
        chk("gate_b",   32'(bus8.gate_b),   32'(m_b));
        chk("pass",     32'(bus8.pass),     32'(m_pass));
        chk("fail_vec", 32'(bus8.fail_vec), 32'(m_fail));
        chk("pass_cnt", 32'(bus8.pass_cnt), 32'(m_pc));
        chk("fail_cnt", 32'(bus8.fail_cnt), 32'(m_fc));
        chk("w2_done",  32'(bus2.done),     32'(m_phase == RUN_LEN + 1));
        chk("w2_fvec",  32'(bus2.fail_vec), 32'(m_fail));
        chk("w2_pcnt",  32'(bus2.pass_cnt), 32'(m_pc2));
        chk("w2_fcnt",  32'(bus2.fail_cnt), 32'(m_fc2));
    end

    // Pulse start; returns at the falling edge inside the first SETTLE cycle.
    task automatic start_run();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input bit poke);
        int lat;
        lat = 1;
        while (!bus8.done && lat < 60) begin
            @(negedge clk);
            lat++;
            start = (poke && lat == 4);
        end
        start = 1'b0;
        chk("run_latency", 32'(lat), 32'd13);
    endtask

    initial begin
        int seen;
        int t_prev;
        int gap;
        int cyc;
        start = 1'b0; abort = 1'b0; mode = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus8.busy), 32'd0);
        chk("rst_pcnt", 32'(bus8.pass_cnt), 32'd0);
        @(negedge clk) reset = 1'b0;

        // Good xnor gate, with a start pulse injected mid-run that must be ignored.
        start_run();
        wait_done(1'b1);
        chk("t1_fvec", 32'(bus8.fail_vec), 32'h0);
        chk("t1_pass", 32'(bus8.pass), 32'd1);
        chk("t1_pcnt", 32'(bus8.pass_cnt), 32'd1);
        @(negedge clk);

        mode = 1;
        start_run(); wait_done(1'b0);
        chk("t2_fvec", 32'(bus8.fail_vec), 32'hF);
        chk("t2_fcnt", 32'(bus8.fail_cnt), 32'd1);
        chk("t2_pcnt", 32'(bus8.pass_cnt), 32'd1);
        @(negedge clk);

        mode = 2;
        start_run(); wait_done(1'b0);
        chk("t3_tie0", 32'(bus8.fail_vec), 32'h9);
        chk("t3_pass", 32'(bus8.pass), 32'd0);
        @(negedge clk);
        mode = 3;
        start_run(); wait_done(1'b0);
        chk("t3_tie1", 32'(bus8.fail_vec), 32'h6);
        @(negedge clk);

        // Abort during vector 2 settle with gate tied low: vector 0 already failed.
        mode = 2;
        start_run();
        repeat (6) @(negedge clk);
        chk("t4_vec2", 32'({bus8.gate_b, bus8.gate_a}), 32'd2);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("t4_busy", 32'(bus8.busy), 32'd0);
        chk("t4_gate", 32'({bus8.gate_b, bus8.gate_a}), 32'd0);
        chk("t4_fvec", 32'(bus8.fail_vec), 32'h1);
        chk("t4_cnts", 32'({bus8.pass_cnt, bus8.fail_cnt}), 32'h0103);
        repeat (15) @(negedge clk);
        chk("t4_cnt2", 32'({bus8.pass_cnt, bus8.fail_cnt}), 32'h0103);
        mode = 0;
        start_run(); wait_done(1'b0);
        chk("t4_fresh", 32'(bus8.pass_cnt), 32'd2);
        @(negedge clk);

        // Asynchronous reset while vector 0 is in CHECK.
        start_run();
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("t5_busy", 32'(bus8.busy), 32'd0);
        chk("t5_gate", 32'({bus8.gate_b, bus8.gate_a}), 32'd0);
        chk("t5_cnts", 32'({bus8.pass_cnt, bus8.fail_cnt}), 32'd0);
        @(negedge clk) reset = 1'b0;
        @(negedge clk);

        // Start held high: back-to-back runs, narrow counter saturates.
        start = 1'b1;
        seen = 0; t_prev = 0; gap = 0; cyc = 0;
        while (seen < 5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus8.done) begin
                if (seen > 0) gap = cyc - t_prev;
                t_prev = cyc;
                seen++;
            end
        end
        start = 1'b0;
        chk("t6_runs", 32'(seen), 32'd5);
        chk("t6_gap", 32'(gap), 32'd14);
        chk("t6_sat2", 32'(bus2.pass_cnt), 32'd3);
        chk("t6_pc8", 32'(bus8.pass_cnt), 32'd5);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
